instr_fetch_unit: RTL

//  Upstream neighbour of the opcode decoder/control unit. Owns the PC, fetches
//  one instruction at a time over a valid/ready instruction-memory interface,

---
 rtl/instr_fetch_unit_pkg.sv | 27 ++
 rtl/instr_fetch_unit_next_pc_sel.sv | 33 +++
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC,
// fetch FSM encoding, RV32I opcode constants and the NOP word.
package instr_fetch_unit_pkg;

    localparam int          IFU_XLEN     = 32;
    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // addi x0, x0, 0 -- the canonical RV32I NOP.
    localparam logic [31:0] NOP_INSTR = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_VALID = 2'd2,
        FETCH_HALT  = 2'd3
    } fetch_state_e;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
        return addr_lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Next-PC priority mux (jalr > jump/branch > sequential) with word-alignment
// check on the selected target.
module instr_fetch_unit_next_pc_sel
    import instr_fetch_unit_pkg::*;
#(
    parameter int XLEN = IFU_XLEN
) (
    input  logic [XLEN-1:0] instr_pc_i,
    input  logic            en_branch_i,
    input  logic            jump_i,
    input  logic            jalr_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic [XLEN-1:0] jalr_target_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            misaligned_o
);

    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] BIT0_CLR = ~XLEN'(1);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        next_pc_o = instr_pc_i + PC_STEP;
        if (jalr_i) begin
            next_pc_o = jalr_target_i & BIT0_CLR;
        end else if (jump_i || en_branch_i) begin
            next_pc_o = branch_target_i;
        end
    end

    assign misaligned_o = !is_word_aligned(next_pc_o[1:0]);

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch: owns the PC, fetches over a
// valid/ready memory port, presents the word to decode and redirects at retire.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int              XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            en_branch,
    input  logic            jump,
    input  logic            jalr,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] jalr_target,
    output logic            fetch_fault,
    output logic [63:0]     instret
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] instr_pc_q;
    logic            fault_q;
    logic [63:0]     instret_q;

    logic [XLEN-1:0] next_pc;
    logic            next_misaligned;
    logic            capture;
    logic            retire;

    assign capture = (state_q == FETCH_WAIT)  && imem_rsp_valid;
    assign retire  = (state_q == FETCH_VALID) && instr_ready;

    // Redirect inputs feed the mux continuously but only matter on retire.
    instr_fetch_unit_next_pc_sel #(
        .XLEN(XLEN)
    ) u_next_pc_sel (
        .instr_pc_i     (instr_pc_q),
        .en_branch_i    (en_branch),
        .jump_i         (jump),
        .jalr_i         (jalr),
        .branch_target_i(branch_target),
        .jalr_target_i  (jalr_target),
        .next_pc_o      (next_pc),
        .misaligned_o   (next_misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_REQ:   if (imem_req_ready) state_d = FETCH_WAIT;
            FETCH_WAIT:  if (imem_rsp_valid) state_d = FETCH_VALID;
            FETCH_VALID: if (instr_ready)    state_d = next_misaligned ? FETCH_HALT : FETCH_REQ;
            FETCH_HALT:  state_d = FETCH_HALT;
            default:     state_d = FETCH_REQ;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        instr_valid    = 1'b0;
        case (state_q)
            FETCH_REQ:   imem_req_valid = 1'b1;
            FETCH_VALID: instr_valid    = 1'b1;
            default: ;
        endcase
    end

    // A misaligned target halts with the PC left at the faulting instruction.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (rst) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
            instret_q  <= 64'd0;
        end else begin
            if (capture) begin
                instr_q    <= imem_rdata;
                instr_pc_q <= pc_q;
            end
            if (retire) begin
                instret_q <= instret_q + 64'd1;
                if (next_misaligned) begin
                    fault_q <= 1'b1;
                end else begin
                    pc_q <= next_pc;
                end
            end
        end
    end

    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_fault = fault_q;
    assign instret     = instret_q;

endmodule
